// File: rtl/control_cmd_decoder.sv
// control_cmd_decoder
// -------------------------------------------------------------------------
// Front-end command stage for control_register. It frames a byte stream
// from the serial receiver into checked commands, issues single write or
// read transactions to control_register, and returns response bytes to
// the serial transmitter.
//
// Frame format: SYNC_BYTE, HDR = {op[7:6], addr[5:0]}, [DATA if op=00], CSUM
//   CSUM = HDR ^ DATA for writes, HDR alone for reads and pings.
//   op: 00 write, 01 read, 10 ping (answers 8'h5A), 11 reserved (error).
//
// Optional build macro: CMD_ACK_EN
//   defined   : a completed write answers 8'h5A, a checksum mismatch answers 8'hEE
//   undefined : a completed write and a checksum mismatch both return silently to IDLE
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   rx_data    received byte               rx_valid  byte valid
//   rx_ready   decoder accepts a byte this cycle
//   cr_wen     write request               cr_ren    read request
//   cr_addr    register address            cr_wdata  write data
//   cr_ack     write accepted (may be same cycle as cr_wen)
//   cr_rdata   read data                   cr_rvalid read data valid
//   tx_data    response byte               tx_valid  response valid
//   tx_ready   transmitter accepts the response
//   err_count  saturating frame-error counter
// -------------------------------------------------------------------------
module control_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         ADDR_W         = 6,
    parameter int         DATA_W         = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              cr_wen,
    output logic              cr_ren,
    output logic [ADDR_W-1:0] cr_addr,
    output logic [DATA_W-1:0] cr_wdata,
    input  logic              cr_ack,
    input  logic [DATA_W-1:0] cr_rdata,
    input  logic              cr_rvalid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        err_count
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      RESP_OK = 8'h5A;
`ifdef CMD_ACK_EN
    localparam logic [7:0]      RESP_NAK = 8'hEE;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_DATA    = 3'd2,
        S_CSUM    = 3'd3,
        S_ISSUE_W = 3'd4,
        S_ISSUE_R = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [7:0]          r_hdr;
    logic [7:0]          r_dat;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_cr_wen;
    logic                r_cr_ren;
    logic [ADDR_W-1:0]   r_cr_addr;
    logic [DATA_W-1:0]   r_cr_wdata;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic [7:0]          r_err_count;

    logic                w_rx_ready;
    logic                w_accept;
    logic [7:0]          w_csum_exp;
    logic                w_csum_ok;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Expected checksum: writes cover HDR and DATA, everything else HDR only.
    function automatic logic [7:0] frame_csum(input logic [1:0] op,
                                              input logic [7:0] hdr,
                                              input logic [7:0] dat);
        return (op == 2'b00) ? (hdr ^ dat) : hdr;
    endfunction

    // The decoder only takes bytes while it is collecting a frame.
    assign w_rx_ready = (r_state == S_IDLE) || (r_state == S_HDR) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept   = rx_valid && w_rx_ready;
    assign w_csum_exp = frame_csum(r_op, r_hdr, r_dat);
    assign w_csum_ok  = (rx_data == w_csum_exp);

    // Frame FSM, inter-byte timeout, transaction issue and response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_hdr       <= 8'h00;
            r_dat       <= 8'h00;
            r_to_cnt    <= '0;
            r_cr_wen    <= 1'b0;
            r_cr_ren    <= 1'b0;
            r_cr_addr   <= '0;
            r_cr_wdata  <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            // Timeout counter only runs inside a frame; frame states override.
            r_to_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    // Non-sync bytes are dropped silently while hunting.
                    if (w_accept && (rx_data == SYNC_BYTE)) begin
                        r_state <= S_HDR;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_HDR, S_DATA, S_CSUM: begin
                    if (w_accept) begin
                        case (r_state)
                            S_HDR: begin
                                r_hdr     <= rx_data;
                                r_op      <= rx_data[7:6];
                                r_cr_addr <= ADDR_W'(rx_data[5:0]);
                                case (rx_data[7:6])
                                    2'b00:   r_state <= S_DATA;
                                    2'b01:   r_state <= S_CSUM;
                                    2'b10:   r_state <= S_CSUM;
                                    default: begin
                                        r_state     <= S_IDLE;
                                        r_err_count <= sat_inc(r_err_count);
                                    end
                                endcase
                            end
                            S_DATA: begin
                                r_dat      <= rx_data;
                                r_cr_wdata <= DATA_W'(rx_data);
                                r_state    <= S_CSUM;
                            end
                            S_CSUM: begin
                                if (w_csum_ok) begin
                                    case (r_op)
                                        2'b00: begin
                                            r_cr_wen <= 1'b1;
                                            r_state  <= S_ISSUE_W;
                                        end
                                        2'b01: begin
                                            r_cr_ren <= 1'b1;
                                            r_state  <= S_ISSUE_R;
                                        end
                                        default: begin
                                            // Ping: answer immediately.
                                            r_tx_data  <= RESP_OK;
                                            r_tx_valid <= 1'b1;
                                            r_state    <= S_RESP;
                                        end
                                    endcase
                                end else begin
                                    r_err_count <= sat_inc(r_err_count);
`ifdef CMD_ACK_EN
                                    r_tx_data  <= RESP_NAK;
                                    r_tx_valid <= 1'b1;
                                    r_state    <= S_RESP;
`else
                                    r_state    <= S_IDLE;
`endif
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else if (r_to_cnt == TO_LAST) begin
                        // Sender stalled mid-frame: abandon the partial frame.
                        r_state     <= S_IDLE;
                        r_err_count <= sat_inc(r_err_count);
                    end else begin
                        r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end

                S_ISSUE_W: begin
                    // Address and data stay put until the register accepts.
                    if (cr_ack) begin
                        r_cr_wen <= 1'b0;
`ifdef CMD_ACK_EN
                        r_tx_data  <= RESP_OK;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
`else
                        r_state    <= S_IDLE;
`endif
                    end else begin
                        r_state <= S_ISSUE_W;
                    end
                end

                S_ISSUE_R: begin
                    if (cr_rvalid) begin
                        r_cr_ren   <= 1'b0;
                        r_tx_data  <= 8'(cr_rdata);
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_state <= S_ISSUE_R;
                    end
                end

                S_RESP: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_cr_wen   <= 1'b0;
                    r_cr_ren   <= 1'b0;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready  = w_rx_ready;
    assign cr_wen    = r_cr_wen;
    assign cr_ren    = r_cr_ren;
    assign cr_addr   = r_cr_addr;
    assign cr_wdata  = r_cr_wdata;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_control_cmd_decoder.sv
// Directed testbench for control_cmd_decoder (TIMEOUT_CYCLES = 16).
module tb_control_cmd_decoder;

    logic       CLK;
    logic       RST;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cr_wen;
    logic       cr_ren;
    logic [5:0] cr_addr;
    logic [7:0] cr_wdata;
    logic       cr_ack;
    logic [7:0] cr_rdata;
    logic       cr_rvalid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] err_count;

    int tests;
    int failed;

    control_cmd_decoder #(
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16), .ADDR_W(6), .DATA_W(8)
    ) dut (
        .CLK(CLK), .RST(RST),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cr_wen(cr_wen), .cr_ren(cr_ren), .cr_addr(cr_addr), .cr_wdata(cr_wdata),
        .cr_ack(cr_ack), .cr_rdata(cr_rdata), .cr_rvalid(cr_rvalid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_count(err_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        RST = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cr_ack = 1'b0;
        cr_rdata = 8'h00; cr_rvalid = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (rx_ready !== 1'b1) begin failed++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
        tests++; if ({cr_wen, cr_ren, tx_valid} !== 3'b000) begin failed++; $display("FAIL reset_strobes got %b exp 000", {cr_wen, cr_ren, tx_valid}); end
        tests++; if ({cr_addr, cr_wdata, tx_data, err_count} !== 30'd0) begin failed++; $display("FAIL reset_values got %h/%h/%h/%h exp 0", cr_addr, cr_wdata, tx_data, err_count); end
    endtask

    task automatic test_write();
        cr_ack = 1'b1;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h39);
        tests++; if (cr_wen !== 1'b1 || cr_ren !== 1'b0) begin failed++; $display("FAIL write_wen got wen=%b ren=%b exp 1/0", cr_wen, cr_ren); end
        tests++; if (cr_addr !== 6'h05 || cr_wdata !== 8'h3C) begin failed++; $display("FAIL write_addr_data got %h/%h exp 05/3C", cr_addr, cr_wdata); end
        tests++; if (rx_ready !== 1'b0) begin failed++; $display("FAIL write_rx_ready got %b exp 0", rx_ready); end
        tick();
        tests++; if (cr_wen !== 1'b0) begin failed++; $display("FAIL write_one_cycle got %b exp 0", cr_wen); end
        tests++; if (err_count !== 8'h00) begin failed++; $display("FAIL write_err got %h exp 00", err_count); end
`ifdef CMD_ACK_EN
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin failed++; $display("FAIL write_ack got v=%b d=%h exp 1/5A", tx_valid, tx_data); end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
`else
        tests++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failed++; $display("FAIL write_no_tx got v=%b rdy=%b exp 0/1", tx_valid, rx_ready); end
        tick();
`endif
        tests++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failed++; $display("FAIL write_idle got v=%b rdy=%b exp 0/1", tx_valid, rx_ready); end
        cr_ack = 1'b0;
    endtask

    task automatic test_sync_as_data();
        cr_ack = 1'b1;
        // HDR 25 (write addr 25), DATA = sync value, CSUM = 25^A5 = 80
        send_byte(8'hA5); send_byte(8'h25); send_byte(8'hA5); send_byte(8'h80);
        tests++; if (cr_wen !== 1'b1 || cr_addr !== 6'h25 || cr_wdata !== 8'hA5) begin failed++; $display("FAIL sync_data got wen=%b %h/%h exp 1 25/A5", cr_wen, cr_addr, cr_wdata); end
        tick();
`ifdef CMD_ACK_EN
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
`endif
        cr_ack = 1'b0;
    endtask

    task automatic test_read_stall();
        send_byte(8'hA5); send_byte(8'h47); send_byte(8'h47);
        tests++; if (cr_ren !== 1'b1 || cr_wen !== 1'b0 || cr_addr !== 6'h07) begin failed++; $display("FAIL read_ren got ren=%b wen=%b a=%h exp 1/0/07", cr_ren, cr_wen, cr_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (cr_ren !== 1'b1 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin failed++; $display("FAIL read_hold got ren=%b rdy=%b v=%b exp 1/0/0", cr_ren, rx_ready, tx_valid); end
        end
        cr_rvalid = 1'b1; cr_rdata = 8'hC3;
        tick();
        cr_rvalid = 1'b0; cr_rdata = 8'h00;
        tests++; if (cr_ren !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hC3) begin failed++; $display("FAIL read_capture got ren=%b v=%b d=%h exp 0/1/C3", cr_ren, tx_valid, tx_data); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (tx_valid !== 1'b1 || tx_data !== 8'hC3 || rx_ready !== 1'b0) begin failed++; $display("FAIL read_tx_stall got v=%b d=%h rdy=%b exp 1/C3/0", tx_valid, tx_data, rx_ready); end
        end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failed++; $display("FAIL read_done got v=%b rdy=%b exp 0/1", tx_valid, rx_ready); end
    endtask

    task automatic test_bad_csum();
        cr_ack = 1'b1;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h00);
        tests++; if (cr_wen !== 1'b0) begin failed++; $display("FAIL badcs_no_wen got %b exp 0", cr_wen); end
        tests++; if (err_count !== 8'h01) begin failed++; $display("FAIL badcs_err got %h exp 01", err_count); end
`ifdef CMD_ACK_EN
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin failed++; $display("FAIL badcs_nak got v=%b d=%h exp 1/EE", tx_valid, tx_data); end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
`else
        tests++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failed++; $display("FAIL badcs_idle got v=%b rdy=%b exp 0/1", tx_valid, rx_ready); end
`endif
        tick();
        tests++; if (cr_wen !== 1'b0 || tx_valid !== 1'b0) begin failed++; $display("FAIL badcs_quiet got wen=%b v=%b exp 0/0", cr_wen, tx_valid); end
        cr_ack = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hA5);
        for (int i = 0; i < 14; i++) tick();
        tests++; if (err_count !== 8'h00) begin failed++; $display("FAIL timeout_early got %h exp 00", err_count); end
        for (int i = 0; i < 6; i++) tick();
        tests++; if (err_count !== 8'h01) begin failed++; $display("FAIL timeout_err got %h exp 01", err_count); end
        send_byte(8'hA5); send_byte(8'h80); send_byte(8'h80);
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A || cr_wen !== 1'b0 || cr_ren !== 1'b0) begin failed++; $display("FAIL timeout_ping got v=%b d=%h wen=%b ren=%b exp 1/5A/0/0", tx_valid, tx_data, cr_wen, cr_ren); end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b0 || err_count !== 8'h01) begin failed++; $display("FAIL timeout_ping_done got v=%b err=%h exp 0/01", tx_valid, err_count); end
    endtask

    task automatic test_garbage_reserved();
        logic [7:0] seq [5];
        logic       act;
        do_reset();
        seq = '{8'h00, 8'hFF, 8'hA5, 8'hC1, 8'hC1};
        act = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i]);
            act = act | cr_wen | cr_ren | tx_valid;
        end
        tick(); tick();
        act = act | cr_wen | cr_ren | tx_valid;
        tests++; if (act !== 1'b0) begin failed++; $display("FAIL garbage_no_activity got %b exp 0", act); end
        tests++; if (err_count !== 8'h01) begin failed++; $display("FAIL garbage_err got %h exp 01", err_count); end
        for (int i = 0; i < 253; i++) begin send_byte(8'hA5); send_byte(8'hC1); end
        tests++; if (err_count !== 8'hFE) begin failed++; $display("FAIL reserved_254 got %h exp FE", err_count); end
        send_byte(8'hA5); send_byte(8'hC1);
        tests++; if (err_count !== 8'hFF) begin failed++; $display("FAIL reserved_255 got %h exp FF", err_count); end
        for (int i = 0; i < 46; i++) begin send_byte(8'hA5); send_byte(8'hC1); end
        tests++; if (err_count !== 8'hFF) begin failed++; $display("FAIL reserved_sat got %h exp FF", err_count); end
    endtask

    task automatic test_reset_mid_write();
        cr_ack = 1'b0;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h39);
        tick();
        tests++; if (cr_wen !== 1'b1) begin failed++; $display("FAIL rstw_wen_held got %b exp 1", cr_wen); end
        RST = 1'b1; tick(); RST = 1'b0;
        tests++; if ({cr_wen, cr_ren, tx_valid, rx_ready} !== 4'b0001) begin failed++; $display("FAIL rstw_strobes got %b exp 0001", {cr_wen, cr_ren, tx_valid, rx_ready}); end
        tests++; if ({cr_addr, cr_wdata, tx_data, err_count} !== 30'd0) begin failed++; $display("FAIL rstw_values got %h/%h/%h/%h exp 0", cr_addr, cr_wdata, tx_data, err_count); end
        cr_ack = 1'b1;
        // CSUM = 12 ^ 55 = 47
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h55); send_byte(8'h47);
        tests++; if (cr_wen !== 1'b1 || cr_addr !== 6'h12 || cr_wdata !== 8'h55) begin failed++; $display("FAIL rstw_new_frame got wen=%b %h/%h exp 1 12/55", cr_wen, cr_addr, cr_wdata); end
        tick();
        tests++; if (cr_wen !== 1'b0 || err_count !== 8'h00) begin failed++; $display("FAIL rstw_new_done got wen=%b err=%h exp 0/00", cr_wen, err_count); end
        cr_ack = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_write();
        test_sync_as_data();
        test_read_stall();
        test_bad_csum();
        test_timeout();
        test_garbage_reserved();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
